fire_weight_loader: RTL



---
 rtl/fire_weight_loader_pkg.sv | 19 +
 rtl/fire_weight_loader_if.sv | 11 +
 rtl/weight_bank_ram.sv | 28 ++
 rtl/fire_weight_loader.sv | 107 ++++++++++
 4 files changed

// File: rtl/fire_weight_loader_pkg.sv
// Shared types and defaults for the fire weight loader and its bank RAMs.
package fire_loader_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_ADDR  = 10;
  localparam int DEF_NUM   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_t;

  // Width of the bank selector; a single bank still needs one bit to hold 0.
  function automatic int bank_idx_width(input int num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

endpackage

// File: rtl/fire_weight_loader_if.sv
// Valid/ready weight stream from the host/DMA side into the loader.
interface fire_weight_loader_if #(
  parameter int WIDTH = fire_loader_pkg::DEF_WIDTH
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/weight_bank_ram.sv
// One weight bank: single write port, registered read-first read port.
module weight_bank_ram #(
  parameter int WIDTH = 16,
  parameter int ADDR  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [ADDR-1:0]  wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [ADDR-1:0]  rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  (* ram_style = "block" *) logic [WIDTH-1:0] mem_reg [2**ADDR];

  // Write port; contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) mem_reg[wr_addr] <= wr_data;
  end

  // Registered read sees the pre-write value on a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem_reg[rd_addr];
  end

endmodule

// File: rtl/fire_weight_loader.sv
// Scatters a weight stream across NUM banks (word k -> bank k%NUM, addr k/NUM)
// and exposes the same parallel registered read port as the ROM banks.
module fire_weight_loader
  import fire_loader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ADDR  = DEF_ADDR,
  parameter int NUM   = DEF_NUM
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR:0]        depth,
  fire_weight_loader_if.slave  s_in,
  output logic                 busy,
  output logic                 load_done,
  input  logic [ADDR-1:0]      address,
  output logic [WIDTH-1:0]     rom_out [NUM]
);

  localparam int BW = bank_idx_width(NUM);
  localparam logic [BW-1:0] LAST_BANK = BW'(NUM - 1);
  localparam logic [ADDR:0] ONE       = (ADDR + 1)'(1);

  load_state_t     state_reg, state_next;
  logic [BW-1:0]   bank_idx_reg, bank_idx_next;
  logic [ADDR-1:0] wr_addr_reg, wr_addr_next;
  logic [ADDR:0]   depth_q_reg, depth_q_next;
  logic            in_ready_c;
  logic            accept;
  logic [NUM-1:0]  bank_we;

  assign s_in.in_ready = in_ready_c;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      bank_idx_reg <= '0;
      wr_addr_reg  <= '0;
      depth_q_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      bank_idx_reg <= bank_idx_next;
      wr_addr_reg  <= wr_addr_next;
      depth_q_reg  <= depth_q_next;
    end
  end

  // Next-state, counter advance and handshake outputs.
  always_comb begin
    state_next    = state_reg;
    bank_idx_next = bank_idx_reg;
    wr_addr_next  = wr_addr_reg;
    depth_q_next  = depth_q_reg;
    in_ready_c    = 1'b0;
    busy          = 1'b0;
    load_done     = 1'b0;
    accept        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          depth_q_next  = depth;
          bank_idx_next = '0;
          wr_addr_next  = '0;
          state_next    = (depth == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        in_ready_c = 1'b1;
        busy       = 1'b1;
        accept     = s_in.in_valid;
        if (accept) begin
          if (bank_idx_reg == LAST_BANK) begin
            bank_idx_next = '0;
            // Last row: leave wr_addr in place so a full-depth load never wraps.
            if ({1'b0, wr_addr_reg} == depth_q_reg - ONE) state_next = DONE;
            else wr_addr_next = wr_addr_reg + 1'b1;
          end else begin
            bank_idx_next = bank_idx_reg + 1'b1;
          end
        end
      end
      DONE: begin
        load_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One-hot write enable per bank plus the bank instances.
  for (genvar gi = 0; gi < NUM; gi++) begin : g_bank
    assign bank_we[gi] = accept && (bank_idx_reg == BW'(gi));

    weight_bank_ram #(.WIDTH(WIDTH), .ADDR(ADDR)) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we      (bank_we[gi]),
      .wr_addr (wr_addr_reg),
      .wr_data (s_in.in_data),
      .rd_addr (address),
      .rd_data (rom_out[gi])
    );
  end

endmodule
